// File: rtl/bad_packet_filter_pkg.sv
// Shared definitions for both stages of the bad-packet filter.
// Stage 2 decodes the BPI byte with the same bit positions.
package bad_packet_filter_pkg;

  localparam int unsigned BPI_BAD   = 0;
  localparam int unsigned BPI_TRUNC = 1;

  typedef enum logic {
    FSM_PASS,
    FSM_DISCARD
  } s1_state_e;

endpackage

// File: rtl/bad_packet_filter_s1_if.sv
// Stage-1 streams: raw AXIS input, packet-FIFO write port, BPI-FIFO write port.
interface bad_packet_filter_s1_if #(
    parameter int unsigned DATA_WBITS = 512,
    parameter int unsigned DATA_WBYTS = DATA_WBITS / 8
);
    logic [DATA_WBITS-1:0] AXIS_IN_TDATA;
    logic [DATA_WBYTS-1:0] AXIS_IN_TKEEP;
    logic                  AXIS_IN_TUSER;
    logic                  AXIS_IN_TLAST;
    logic                  AXIS_IN_TVALID;
    logic                  AXIS_IN_TREADY;

    logic [DATA_WBITS-1:0] fpkt_in_tdata;
    logic [DATA_WBYTS-1:0] fpkt_in_tkeep;
    logic                  fpkt_in_tuser;
    logic                  fpkt_in_tlast;
    logic                  fpkt_in_tvalid;
    logic                  fpkt_in_tready;

    logic [7:0]            fbpi_in_tdata;
    logic                  fbpi_in_tvalid;
    logic                  fbpi_in_tready;

    // Filter side: sinks the raw stream, sources both FIFO write ports.
    modport slave (
        input  AXIS_IN_TDATA, AXIS_IN_TKEEP, AXIS_IN_TUSER, AXIS_IN_TLAST, AXIS_IN_TVALID,
        output AXIS_IN_TREADY,
        output fpkt_in_tdata, fpkt_in_tkeep, fpkt_in_tuser, fpkt_in_tlast, fpkt_in_tvalid,
        input  fpkt_in_tready,
        output fbpi_in_tdata, fbpi_in_tvalid,
        input  fbpi_in_tready
    );

    modport master (
        output AXIS_IN_TDATA, AXIS_IN_TKEEP, AXIS_IN_TUSER, AXIS_IN_TLAST, AXIS_IN_TVALID,
        input  AXIS_IN_TREADY,
        input  fpkt_in_tdata, fpkt_in_tkeep, fpkt_in_tuser, fpkt_in_tlast, fpkt_in_tvalid,
        output fpkt_in_tready,
        input  fbpi_in_tdata, fbpi_in_tvalid,
        output fbpi_in_tready
    );

endinterface

// File: rtl/bad_packet_filter_s1.sv
// Bad-packet filter stage 1: forwards beats to the packet FIFO, emits one BPI byte per
// packet, and truncates packets longer than MAX_BEATS so stage 2 cannot deadlock.
module bad_packet_filter_s1
    import bad_packet_filter_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 128
) (
    input  logic                   clk,
    input  logic                   resetn,
    bad_packet_filter_s1_if.slave  bus,
    output logic [31:0]            pkt_count,
    output logic [31:0]            bad_count,
    output logic                   oversize_seen
);

    localparam int unsigned CntW = $clog2(MAX_BEATS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BEATS - 1);

    s1_state_e       state_q, state_d;
    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
    logic            user_seen_q, user_seen_d;
    logic [31:0]     pkt_count_q, pkt_count_d;
    logic [31:0]     bad_count_q, bad_count_d;
    logic            oversize_q, oversize_d;

    logic       end_beat;
    logic       truncated;
    logic [7:0] bpi;
    logic       in_hs;

    always_comb begin
        end_beat        = bus.AXIS_IN_TLAST | (beat_cnt_q == LastCnt);
        truncated       = end_beat & ~bus.AXIS_IN_TLAST;
        bpi             = '0;
        bpi[BPI_BAD]    = user_seen_q | bus.AXIS_IN_TUSER | truncated;
        bpi[BPI_TRUNC]  = truncated;

        bus.fpkt_in_tdata = bus.AXIS_IN_TDATA;
        bus.fpkt_in_tkeep = bus.AXIS_IN_TKEEP;
        bus.fpkt_in_tuser = bus.AXIS_IN_TUSER;
        bus.fpkt_in_tlast = end_beat;
        bus.fbpi_in_tdata = bpi;

        bus.AXIS_IN_TREADY  = 1'b0;
        bus.fpkt_in_tvalid  = 1'b0;
        bus.fbpi_in_tvalid  = 1'b0;
        in_hs               = 1'b0;

        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        user_seen_d = user_seen_q;
        pkt_count_d = pkt_count_q;
        bad_count_d = bad_count_q;
        oversize_d  = oversize_q;

        unique case (state_q)
            FSM_PASS: begin
                // Requiring both FIFOs ready keeps TREADY independent of TLAST.
                bus.AXIS_IN_TREADY = bus.fpkt_in_tready & bus.fbpi_in_tready;
                bus.fpkt_in_tvalid = bus.AXIS_IN_TVALID & bus.fbpi_in_tready;
                bus.fbpi_in_tvalid = bus.AXIS_IN_TVALID & bus.fpkt_in_tready & end_beat;
                in_hs              = bus.AXIS_IN_TVALID & bus.AXIS_IN_TREADY;
                if (in_hs) begin
                    if (end_beat) begin
                        beat_cnt_d  = '0;
                        user_seen_d = 1'b0;
                        pkt_count_d = pkt_count_q + 32'd1;
                        if (bpi[BPI_BAD]) bad_count_d = bad_count_q + 32'd1;
                        if (truncated) begin
                            oversize_d = 1'b1;
                            state_d    = FSM_DISCARD;
                        end
                    end else begin
                        beat_cnt_d  = beat_cnt_q + CntW'(1);
                        user_seen_d = user_seen_q | bus.AXIS_IN_TUSER;
                    end
                end
            end
            FSM_DISCARD: begin
                bus.AXIS_IN_TREADY = 1'b1;
                if (bus.AXIS_IN_TVALID && bus.AXIS_IN_TLAST) state_d = FSM_PASS;
            end
            default: state_d = FSM_PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= FSM_PASS;
            beat_cnt_q  <= '0;
            user_seen_q <= 1'b0;
            pkt_count_q <= '0;
            bad_count_q <= '0;
            oversize_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            user_seen_q <= user_seen_d;
            pkt_count_q <= pkt_count_d;
            bad_count_q <= bad_count_d;
            oversize_q  <= oversize_d;
        end
    end

    assign pkt_count     = pkt_count_q;
    assign bad_count     = bad_count_q;
    assign oversize_seen = oversize_q;

endmodule

// File: tb/tb_bad_packet_filter_s1.sv
// Bench for bad_packet_filter_s1 with MAX_BEATS=4: vector table plus stall/reset sequences,
// FIFO writes matched against a scoreboard of expected beats and BPI bytes.
module tb_bad_packet_filter_s1;
    import bad_packet_filter_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned MB = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] pkt_count, bad_count;
    logic        oversize_seen;

    bad_packet_filter_s1_if #(.DATA_WBITS(DW)) bus ();

    bad_packet_filter_s1 #(.MAX_BEATS(MB)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .bus           (bus),
        .pkt_count     (pkt_count),
        .bad_count     (bad_count),
        .oversize_seen (oversize_seen)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          user;
        logic          last;
    } beat_t;

    typedef struct {
        logic v, u, l, pr, br;
        logic er, ep, el, eb;
        logic [7:0] bpi;
    } vec_t;

    beat_t      pkt_q[$];
    logic [7:0] bpi_q[$];
    logic [DW-1:0] data_seq = '0;
    beat_t      exp_beat;
    logic [7:0] exp_bpi;
    vec_t       tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs driven 1ns after posedge; outputs checked at the following negedge.
    task automatic cyc(input vec_t t, input string tag);
        @(posedge clk);
        #1;
        data_seq = data_seq + 64'h0000_0001_0000_0101;
        bus.AXIS_IN_TVALID = t.v;
        bus.AXIS_IN_TDATA  = data_seq;
        bus.AXIS_IN_TKEEP  = data_seq[KW-1:0];
        bus.AXIS_IN_TUSER  = t.u;
        bus.AXIS_IN_TLAST  = t.l;
        bus.fpkt_in_tready = t.pr;
        bus.fbpi_in_tready = t.br;
        if (t.ep) pkt_q.push_back('{data: data_seq, keep: data_seq[KW-1:0], user: t.u, last: t.el});
        if (t.eb) bpi_q.push_back(t.bpi);
        @(negedge clk);
        check({tag, " tready"}, 64'(bus.AXIS_IN_TREADY), 64'(t.er));
    endtask

    task automatic idle(input string tag);
        cyc('{v:0, u:0, l:0, pr:1, br:1, er:1, ep:0, el:0, eb:0, bpi:8'h00}, tag);
    endtask

    task automatic check_cnt(input string tag, input int p, input int b, input logic ov);
        check({tag, " pkt_count"}, 64'(pkt_count), 64'(p));
        check({tag, " bad_count"}, 64'(bad_count), 64'(b));
        check({tag, " oversize"}, 64'(oversize_seen), 64'(ov));
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (bus.fpkt_in_tvalid && bus.fpkt_in_tready) begin
                if (pkt_q.size() == 0) begin
                    check("fpkt unexpected write", 64'd1, 64'd0);
                end else begin
                    exp_beat = pkt_q.pop_front();
                    check("fpkt tdata", bus.fpkt_in_tdata, exp_beat.data);
                    check("fpkt keep/user/last",
                          64'({bus.fpkt_in_tkeep, bus.fpkt_in_tuser, bus.fpkt_in_tlast}),
                          64'({exp_beat.keep, exp_beat.user, exp_beat.last}));
                end
            end
            if (bus.fbpi_in_tvalid && bus.fbpi_in_tready) begin
                if (bpi_q.size() == 0) begin
                    check("fbpi unexpected write", 64'd1, 64'd0);
                end else begin
                    exp_bpi = bpi_q.pop_front();
                    check("fbpi tdata", 64'(bus.fbpi_in_tdata), 64'(exp_bpi));
                end
            end
        end
    end

    initial begin
        bus.AXIS_IN_TVALID = 1'b0;
        bus.AXIS_IN_TDATA  = '0;
        bus.AXIS_IN_TKEEP  = '0;
        bus.AXIS_IN_TUSER  = 1'b0;
        bus.AXIS_IN_TLAST  = 1'b0;
        bus.fpkt_in_tready = 1'b1;
        bus.fbpi_in_tready = 1'b1;

        // Fields: v u l pr br | er ep el eb bpi
        // 3-beat clean packet
        tbl.push_back('{1,0,0,1,1, 1,1,0,0, 8'h00});
        tbl.push_back('{1,0,0,1,1, 1,1,0,0, 8'h00});
        tbl.push_back('{1,0,1,1,1, 1,1,1,1, 8'h00});
        // 4-beat packet, TUSER on beat 2
        tbl.push_back('{1,0,0,1,1, 1,1,0,0, 8'h00});
        tbl.push_back('{1,1,0,1,1, 1,1,0,0, 8'h00});
        tbl.push_back('{1,0,0,1,1, 1,1,0,0, 8'h00});
        tbl.push_back('{1,0,1,1,1, 1,1,1,1, 8'h01});
        // exactly MAX_BEATS, clean: not truncated
        tbl.push_back('{1,0,0,1,1, 1,1,0,0, 8'h00});
        tbl.push_back('{1,0,0,1,1, 1,1,0,0, 8'h00});
        tbl.push_back('{1,0,0,1,1, 1,1,0,0, 8'h00});
        tbl.push_back('{1,0,1,1,1, 1,1,1,1, 8'h00});
        // idle gap with FIFOs busy: TREADY low in PASS
        tbl.push_back('{0,0,0,0,1, 0,0,0,0, 8'h00});
        // 7-beat packet: truncated at beat 4, tail dropped (FIFOs busy in DISCARD too)
        tbl.push_back('{1,0,0,1,1, 1,1,0,0, 8'h00});
        tbl.push_back('{1,0,0,1,1, 1,1,0,0, 8'h00});
        tbl.push_back('{1,0,0,1,1, 1,1,0,0, 8'h00});
        tbl.push_back('{1,0,0,1,1, 1,1,1,1, 8'h03});
        tbl.push_back('{1,1,0,0,0, 1,0,0,0, 8'h00});
        tbl.push_back('{1,0,0,1,1, 1,0,0,0, 8'h00});
        tbl.push_back('{1,0,1,1,1, 1,0,0,0, 8'h00});
        // following 2-beat packet is clean
        tbl.push_back('{1,0,0,1,1, 1,1,0,0, 8'h00});
        tbl.push_back('{1,0,1,1,1, 1,1,1,1, 8'h00});

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset tready", 64'(bus.AXIS_IN_TREADY), 64'd1);
        check("reset fpkt valid", 64'(bus.fpkt_in_tvalid), 64'd0);
        check("reset fbpi valid", 64'(bus.fbpi_in_tvalid), 64'd0);
        check_cnt("reset", 0, 0, 1'b0);
        @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i], $sformatf("vec%0d", i));
            if (i == 10) begin
                idle("after exact");
                check_cnt("after exact", 3, 1, 1'b0);
            end
        end
        idle("after table");
        check_cnt("after table", 5, 2, 1'b1);

        // BPI FIFO full for 5 cycles on a 1-beat packet: nothing written
        for (int i = 0; i < 5; i++)
            cyc('{1,0,1,1,0, 0,0,0,0, 8'h00}, $sformatf("bpi stall%0d", i));
        cyc('{1,0,1,0,1, 0,0,0,0, 8'h00}, "pkt stall");
        cyc('{1,0,1,1,1, 1,1,1,1, 8'h00}, "stall release");
        idle("after stall");
        check_cnt("after stall", 6, 2, 1'b1);

        // reset after 2 beats of a 5-beat packet (beat 2 carries TUSER)
        cyc('{1,0,0,1,1, 1,1,0,0, 8'h00}, "pre-reset b1");
        cyc('{1,1,0,1,1, 1,1,0,0, 8'h00}, "pre-reset b2");
        @(posedge clk);
        #1;
        bus.AXIS_IN_TVALID = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check_cnt("after reset", 0, 0, 1'b0);
        cyc('{1,0,0,1,1, 1,1,0,0, 8'h00}, "post-reset b1");
        cyc('{1,0,0,1,1, 1,1,0,0, 8'h00}, "post-reset b2");
        cyc('{1,0,1,1,1, 1,1,1,1, 8'h00}, "post-reset b3");
        idle("post-reset end");
        check_cnt("post-reset", 1, 0, 1'b0);

        check("pkt scoreboard drained", 64'(pkt_q.size()), 64'd0);
        check("bpi scoreboard drained", 64'(bpi_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bad_packet_filter_s1.md
# bad_packet_filter_s1

Front half of the two-stage bad-packet filter. Accepts a raw AXI-Stream packet stream and writes every beat into the packet FIFO. At each packet end it writes one bad-packet-indicator (BPI) byte into the BPI FIFO, which `bad_packet_filter_s2` consumes. It also truncates packets too long for the packet FIFO, so stage 2 can never deadlock waiting for a BPI entry that cannot be produced.

## Interface
Parameters:
- `DATA_WBITS`, 512: data width in bits.
- `DATA_WBYTS`, `DATA_WBITS/8`: keep width.
- `MAX_BEATS`, 128: max beats per packet stored. Must be ≥1 and ≤ packet-FIFO depth.

Ports:
- `clk`  in  1: the single clock.
- `resetn`  in  1: synchronous, active-low reset.
- `AXIS_IN_TDATA/TKEEP`  in  DATA_WBITS/DATA_WBYTS: input packet data.
- `AXIS_IN_TUSER`  in  1: error marker on a beat.
- `AXIS_IN_TLAST`, `AXIS_IN_TVALID`  in  1: input stream control.
- `AXIS_IN_TREADY`  out  1: input stream ready.
- `fpkt_in_tdata/tkeep`  out  DATA_WBITS/DATA_WBYTS: packet FIFO write data.
- `fpkt_in_tuser`, `fpkt_in_tlast`, `fpkt_in_tvalid`  out  1: packet FIFO write control.
- `fpkt_in_tready`  in  1: packet FIFO ready.
- `fbpi_in_tdata`  out  8: BPI byte.
- `fbpi_in_tvalid`  out  1: BPI FIFO write valid.
- `fbpi_in_tready`  in  1: BPI FIFO ready.
- `pkt_count`  out  32: BPI entries written, i.e. packets delivered to stage 2.
- `bad_count`  out  32: BPI entries written with bit0=1.
- `oversize_seen`  out  1: sticky; a packet was truncated.

## Operation
- States:
  - `FSM_PASS` (reset state): forwarding beats.
  - `FSM_DISCARD`: draining the tail of a truncated packet.
- `beat_cnt`: beats written so far in the current packet. Width `$clog2(MAX_BEATS+1)`.
- `user_seen`: sticky OR of TUSER over the packet's earlier beats.
- End beat (PASS): `AXIS_IN_TLAST | (beat_cnt == MAX_BEATS-1)`.
- Behaviour in PASS:
  - `AXIS_IN_TREADY = fpkt_in_tready & fbpi_in_tready`. Both FIFOs must be ready, so the end beat always lands in both FIFOs on the same cycle.
  - `fpkt_in_tvalid = AXIS_IN_TVALID & fbpi_in_tready`.
  - `fbpi_in_tvalid = AXIS_IN_TVALID & fpkt_in_tready & end_beat`.
  - `fpkt_in_tdata/tkeep/tuser` are direct from input.
  - `fpkt_in_tlast = end_beat`.
- BPI byte:
  - bit0 = `user_seen | AXIS_IN_TUSER | truncated`.
  - bit1 = `truncated`, where `truncated = end_beat & ~AXIS_IN_TLAST`.
  - bits 7:2 = 0.
- On a PASS handshake:
  - Non-end beat: `beat_cnt++`, `user_seen |= TUSER`.
  - End beat: `beat_cnt←0`, `user_seen←0`, `pkt_count++`, and `bad_count++` if bit0 is set.
  - Truncated end beat: additionally `oversize_seen←1` and next state `FSM_DISCARD`.
- Behaviour in DISCARD:
  - `AXIS_IN_TREADY=1`; both FIFO valids are 0.
  - On an input handshake with TLAST=1, return to PASS. Non-last beats are dropped.
- A packet of exactly `MAX_BEATS` beats whose final beat has TLAST=1 is not truncated (bit1=0) and does not enter DISCARD.
- Counters wrap modulo 2^32.

## Timing
- Data path is combinational: zero latency. Input beat and FIFO write happen in the same cycle.
- `pkt_count`, `bad_count`, `oversize_seen` update on the clock edge after the end-beat handshake.
- No output may depend combinationally on `*_tvalid` of its own channel; TREADY depends only on FIFO readies and state.
- Reset values:
  - state `FSM_PASS`; `beat_cnt`, `user_seen`, all counters, and `oversize_seen` = 0.
  - Combinational outputs follow from the reset state, with no valid asserted unless `AXIS_IN_TVALID` is high.
- Reset mid-packet: state returns to PASS with counts cleared. The FIFOs share `resetn`, so the partial packet is flushed with them. The first post-reset beat starts a new packet.
- A BPI FIFO full while the packet FIFO is ready stalls the input, even on non-end beats. This is deliberate and keeps TREADY independent of TLAST.

## Structure
- Shared package `bad_packet_filter_pkg`:
  - BPI bit positions `BPI_BAD=0`, `BPI_TRUNC=1`.
  - FSM state localparams.
  - Stage 2 reads `BPI_BAD` from the same package.
- Single flat module; no sub-module needed.
- FIFOs are instantiated by the parent alongside `bad_packet_filter_s2`.

## Test plan
- 3-beat packet, TUSER=0 everywhere, FIFOs always ready -> 3 fpkt writes, last with tlast=1; one BPI 0x00; `pkt_count=1`, `bad_count=0`.
- 4-beat packet, TUSER=1 on beat 2 only -> BPI 0x01; `bad_count=1`; all 4 beats written.
- `MAX_BEATS=4`, 7-beat packet, TUSER=0 -> 4 fpkt writes with beat 4 tlast=1; BPI 0x03; beats 5–7 accepted and dropped; `oversize_seen=1`. Next 2-beat packet -> BPI 0x00.
- `MAX_BEATS=4`, exactly 4-beat packet with TLAST on beat 4 -> BPI 0x00; stays in PASS; `oversize_seen=0`.
- `fbpi_in_tready` held low 5 cycles during a 1-beat packet -> `AXIS_IN_TREADY=0` for those cycles; no writes to either FIFO; the beat and BPI are written together on the first ready cycle.
- Assert `resetn=0` for 1 cycle after 2 beats of a 5-beat packet -> counters 0; next packet starts with `beat_cnt=0`; its BPI reflects only post-reset beats.
